// File: rtl/oc8051_icache_dm.sv
// Direct-mapped instruction cache for the oc8051 fetch port: parametrised size/line,
// whole-cache flush, uncached bypass and Wishbone bus-error reporting.
//
// state    | meaning
// S_IDLE   | waiting for a CPU request; RAMs read at the incoming address
// S_LOOKUP | tag compare; hit answers the CPU directly
// S_REFILL | Wishbone burst filling the whole line
// S_RESP   | one-cycle answer after refill or bypass (data or error)
// S_BYPASS | single uncached Wishbone read
module oc8051_icache_dm #(
  parameter int ADR_WIDTH  = 6,
  parameter int LINE_WIDTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  input  logic        flush_i,
  input  logic [15:0] adr_i,
  input  logic        stb_i,
  input  logic        cyc_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        err_o,
  output logic [15:0] adr_o,
  input  logic [31:0] dat_i,
  output logic        stb_o,
  output logic        cyc_o,
  input  logic        ack_i,
  input  logic        err_i
);
  localparam int INDEX = ADR_WIDTH - LINE_WIDTH;
  localparam int TAG   = 14 - ADR_WIDTH;
  localparam int LINES = 1 << INDEX;
  localparam int WORDS = 1 << ADR_WIDTH;

  typedef enum logic [2:0] {S_IDLE, S_LOOKUP, S_REFILL, S_RESP, S_BYPASS} state_t;

  state_t                state_q, state_d;
  logic [13:0]           wadr_q, wadr_d;
  logic [LINE_WIDTH-1:0] beat_q, beat_d;
  logic                  err_q, err_d;
  logic [31:0]           resp_q, resp_d;
  logic                  flushed_q, flushed_d;
  logic [LINES-1:0]      valid_q, valid_d;

  logic [31:0]    data_ram [WORDS];
  logic [TAG-1:0] tag_ram  [LINES];
  logic [31:0]    rd_dat_q;
  logic [TAG-1:0] rd_tag_q;

  logic                  req, hit, ram_we, tag_we;
  logic [INDEX-1:0]      idx_q;
  logic [TAG-1:0]        tag_q;
  logic [LINE_WIDTH-1:0] off_q;
  logic                  unused_adr;

  assign unused_adr = ^adr_i[1:0];
  assign idx_q = wadr_q[ADR_WIDTH-1:LINE_WIDTH];
  assign tag_q = wadr_q[13:ADR_WIDTH];
  assign off_q = wadr_q[LINE_WIDTH-1:0];
  assign req   = stb_i & cyc_i & ~ack_o;
  assign hit   = valid_q[idx_q] && (rd_tag_q == tag_q);
  assign cyc_o = stb_o;

  always_comb begin
    state_d   = state_q;
    wadr_d    = wadr_q;
    beat_d    = beat_q;
    err_d     = err_q;
    resp_d    = resp_q;
    flushed_d = flushed_q | flush_i;
    valid_d   = valid_q;
    ram_we    = 1'b0;
    tag_we    = 1'b0;
    ack_o     = 1'b0;
    err_o     = 1'b0;
    dat_o     = '0;
    adr_o     = '0;
    stb_o     = 1'b0;
    case (state_q)
      S_IDLE: begin
        wadr_d    = adr_i[15:2];
        beat_d    = '0;
        err_d     = 1'b0;
        resp_d    = '0;
        flushed_d = 1'b0;
        if (req) state_d = en_i ? S_LOOKUP : S_BYPASS;
      end
      S_LOOKUP: begin
        if (hit) begin
          ack_o   = 1'b1;
          dat_o   = rd_dat_q;
          state_d = S_IDLE;
        end else begin
          state_d = S_REFILL;
        end
      end
      S_REFILL: begin
        stb_o = 1'b1;
        adr_o = {tag_q, idx_q, beat_q, 2'b00};
        if (err_i) begin
          err_d          = 1'b1;
          resp_d         = '0;
          valid_d[idx_q] = 1'b0;
          state_d        = S_RESP;
        end else if (ack_i) begin
          ram_we = 1'b1;
          beat_d = beat_q + LINE_WIDTH'(1);
          if (beat_q == off_q) resp_d = dat_i;
          if (&beat_q) begin
            // A flush seen anywhere in the burst keeps the line invalid.
            tag_we         = 1'b1;
            valid_d[idx_q] = ~flushed_q;
            state_d        = S_RESP;
          end
        end
      end
      S_BYPASS: begin
        stb_o = 1'b1;
        adr_o = {wadr_q, 2'b00};
        if (err_i) begin
          err_d   = 1'b1;
          resp_d  = '0;
          state_d = S_RESP;
        end else if (ack_i) begin
          resp_d  = dat_i;
          state_d = S_RESP;
        end
      end
      S_RESP: begin
        ack_o   = 1'b1;
        err_o   = err_q;
        dat_o   = resp_q;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) valid_d = '0;
    // Reset drops the bus and CPU handshake in the same cycle it is raised.
    if (rst) begin
      stb_o = 1'b0;
      adr_o = '0;
      ack_o = 1'b0;
      err_o = 1'b0;
      dat_o = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      wadr_q    <= '0;
      beat_q    <= '0;
      err_q     <= 1'b0;
      resp_q    <= '0;
      flushed_q <= 1'b0;
      valid_q   <= '0;
    end else begin
      state_q   <= state_d;
      wadr_q    <= wadr_d;
      beat_q    <= beat_d;
      err_q     <= err_d;
      resp_q    <= resp_d;
      flushed_q <= flushed_d;
      valid_q   <= valid_d;
    end
  end

  always_ff @(posedge clk) begin
    if (ram_we) data_ram[{idx_q, beat_q}] <= dat_i;
    if (tag_we) tag_ram[idx_q] <= tag_q;
    if (state_q == S_IDLE) begin
      rd_dat_q <= data_ram[adr_i[ADR_WIDTH+1:2]];
      rd_tag_q <= tag_ram[adr_i[ADR_WIDTH+1:LINE_WIDTH+2]];
    end
  end
endmodule

// File: tb/tb_oc8051_icache_dm.sv
// Bench for oc8051_icache_dm: directed vector table, multi-cycle corner sequences,
// then random fetches checked against a line/tag model of the cache.
module tb_oc8051_icache_dm;
  logic        clk = 1'b0;
  logic        rst, en_i, flush_i, stb_i, cyc_i;
  logic [15:0] adr_i;
  logic [31:0] dat_o, dat_i;
  logic        ack_o, err_o, stb_o, cyc_o, ack_i, err_i;
  logic [15:0] adr_o;

  oc8051_icache_dm #(.ADR_WIDTH(6), .LINE_WIDTH(2)) dut (
    .clk(clk), .rst(rst), .en_i(en_i), .flush_i(flush_i), .adr_i(adr_i),
    .stb_i(stb_i), .cyc_i(cyc_i), .dat_o(dat_o), .ack_o(ack_o), .err_o(err_o),
    .adr_o(adr_o), .dat_i(dat_i), .stb_o(stb_o), .cyc_o(cyc_o),
    .ack_i(ack_i), .err_i(err_i));

  always #5 clk = ~clk;

  int n_chk = 0, n_fail = 0;
  int total_beats = 0, xfer_beats = 0, err_beat = 0, wait_cnt = 0, max_wait = 0;
  logic [15:0] first_adr, last_adr;
  logic prev_ack = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Wishbone slave: memory word equals its byte address.
  always @(negedge clk) begin
    ack_i = 1'b0;
    err_i = 1'b0;
    dat_i = 32'hDEAD_BEEF;
    if (stb_o && !rst) begin
      if (wait_cnt == 0) begin
        xfer_beats++;
        total_beats++;
        if (xfer_beats == 1) first_adr = adr_o;
        else chk("burst_adr_step", {16'h0, adr_o}, {16'h0, last_adr + 16'd4});
        last_adr = adr_o;
        if (xfer_beats == err_beat) err_i = 1'b1;
        else begin
          ack_i = 1'b1;
          dat_i = {16'h0, adr_o};
        end
        wait_cnt = $urandom_range(0, max_wait);
      end else wait_cnt--;
    end else xfer_beats = 0;
  end

  always @(negedge clk) begin
    chk("cyc_eq_stb", {31'h0, cyc_o}, {31'h0, stb_o});
    if (prev_ack) chk("ack_not_back_to_back", {31'h0, ack_o}, 32'h0);
    prev_ack = ack_o;
  end

  task automatic fetch(input logic [15:0] a, input bit en, input int eb,
                       output logic [31:0] d, output bit e, output int beats, output int lat);
    int b0;
    bit got;
    b0 = total_beats;
    err_beat = eb;
    en_i = en; adr_i = a; stb_i = 1'b1; cyc_i = 1'b1;
    lat = 0; d = '0; e = 1'b0; got = 1'b0;
    for (int i = 0; i < 300 && !got; i++) begin
      @(negedge clk);
      lat++;
      if (ack_o) begin got = 1'b1; d = dat_o; e = err_o; end
    end
    if (!got) begin
      n_chk++; n_fail++;
      $display("FAIL fetch_timeout: no ack_o for address %h", a);
    end
    @(posedge clk); #1;
    stb_i = 1'b0; cyc_i = 1'b0; err_beat = 0;
    beats = total_beats - b0;
  endtask

  task automatic pulse_flush;
    flush_i = 1'b1;
    @(posedge clk); #1;
    flush_i = 1'b0;
  endtask

  typedef struct {
    logic [15:0] addr; bit en; bit flush; int eb;
    logic [31:0] dat; bit err; int beats; int lat;
  } vec_t;

  // Reference model: line valid/tag per index, 16 lines of 4 words.
  bit         m_valid [16];
  logic [9:0] m_tag   [16];

  task automatic model_fetch(input logic [15:0] a, input bit en, input int eb,
                             output logic [31:0] d, output bit e, output int beats, output int lat);
    int line;
    line = (a >> 4) % 16;
    lat = 0;
    if (!en) begin
      beats = 1; e = (eb == 1); d = e ? 32'h0 : {16'h0, a & 16'hFFFC};
    end else if (m_valid[line] && m_tag[line] == 10'(a >> 6)) begin
      beats = 0; e = 1'b0; d = {16'h0, a & 16'hFFFC}; lat = 2;
    end else if (eb != 0) begin
      beats = eb; e = 1'b1; d = 32'h0; m_valid[line] = 1'b0;
    end else begin
      beats = 4; e = 1'b0; d = {16'h0, a & 16'hFFFC};
      m_valid[line] = 1'b1; m_tag[line] = 10'(a >> 6);
    end
  endtask

  vec_t vt[$];
  logic [31:0] d, md;
  bit e, me;
  int beats, lat, mbeats, mlat;
  logic [15:0] a;

  task automatic check_fetch(input string tag, input logic [15:0] fa, input bit en,
                             input logic [31:0] xd, input bit xe, input int xb, input int xl);
    chk({tag, "_dat"}, d, xd);
    chk({tag, "_err"}, {31'h0, e}, {31'h0, xe});
    chk({tag, "_beats"}, beats, xb);
    if (xl != 0) chk({tag, "_latency"}, lat, xl);
    if (beats > 0)
      chk({tag, "_first_adr"}, {16'h0, first_adr},
          {16'h0, en ? (fa & 16'hFFF0) : (fa & 16'hFFFC)});
    if (beats == 4) chk({tag, "_last_adr"}, {16'h0, last_adr}, {16'h0, (fa & 16'hFFF0) + 16'd12});
  endtask

  initial begin
    rst = 1'b1; en_i = 1'b1; flush_i = 1'b0; stb_i = 1'b0; cyc_i = 1'b0; adr_i = '0;
    ack_i = 1'b0; err_i = 1'b0; dat_i = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_ack_o", {31'h0, ack_o}, 32'h0);
    chk("rst_err_o", {31'h0, err_o}, 32'h0);
    chk("rst_stb_o", {31'h0, stb_o}, 32'h0);
    chk("rst_cyc_o", {31'h0, cyc_o}, 32'h0);
    chk("rst_dat_o", dat_o, 32'h0);
    chk("rst_adr_o", {16'h0, adr_o}, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;

    //               addr     en  fl  eb  dat           err beats lat
    vt.push_back('{16'h0104, 1, 0, 0, 32'h0000_0104, 0, 4, 0});
    vt.push_back('{16'h0108, 1, 0, 0, 32'h0000_0108, 0, 0, 2});
    vt.push_back('{16'h0100, 1, 0, 0, 32'h0000_0100, 0, 0, 2});
    vt.push_back('{16'h0200, 1, 0, 0, 32'h0000_0200, 0, 4, 0});
    vt.push_back('{16'h0100, 1, 0, 0, 32'h0000_0100, 0, 4, 0});
    vt.push_back('{16'h010C, 1, 1, 0, 32'h0000_010C, 0, 4, 0});
    vt.push_back('{16'h0102, 1, 0, 0, 32'h0000_0100, 0, 0, 2});
    vt.push_back('{16'h0400, 1, 0, 2, 32'h0000_0000, 1, 2, 0});
    vt.push_back('{16'h0400, 1, 0, 0, 32'h0000_0400, 0, 4, 0});
    vt.push_back('{16'h0300, 0, 0, 0, 32'h0000_0300, 0, 1, 0});
    vt.push_back('{16'h0300, 1, 0, 0, 32'h0000_0300, 0, 4, 0});
    vt.push_back('{16'h0340, 0, 0, 1, 32'h0000_0000, 1, 1, 0});
    vt.push_back('{16'h0300, 1, 0, 0, 32'h0000_0300, 0, 0, 2});
    foreach (vt[i]) begin
      if (vt[i].flush) pulse_flush();
      fetch(vt[i].addr, vt[i].en, vt[i].eb, d, e, beats, lat);
      check_fetch($sformatf("vec%0d", i), vt[i].addr, vt[i].en,
                  vt[i].dat, vt[i].err, vt[i].beats, vt[i].lat);
    end

    // Flush landing in the LOOKUP cycle of a hit: hit still served, later miss.
    fork
      fetch(16'h0304, 1, 0, d, e, beats, lat);
      begin @(posedge clk); #1 flush_i = 1'b1; @(posedge clk); #1 flush_i = 1'b0; end
    join
    check_fetch("flush_on_hit", 16'h0304, 1, 32'h0000_0304, 0, 0, 2);
    fetch(16'h0304, 1, 0, d, e, beats, lat);
    check_fetch("after_flush_on_hit", 16'h0304, 1, 32'h0000_0304, 0, 4, 0);

    // Flush during the third refill beat: word returned, line left invalid.
    fork
      fetch(16'h0508, 1, 0, d, e, beats, lat);
      begin
        for (int i = 0; i < 200 && xfer_beats < 3; i++) begin @(negedge clk); #1; end
        flush_i = 1'b1; @(posedge clk); #1 flush_i = 1'b0;
      end
    join
    check_fetch("flush_beat3", 16'h0508, 1, 32'h0000_0508, 0, 4, 0);
    fetch(16'h0500, 1, 0, d, e, beats, lat);
    check_fetch("after_flush_beat3", 16'h0500, 1, 32'h0000_0500, 0, 4, 0);

    // Reset in the middle of a refill burst.
    en_i = 1'b1; adr_i = 16'h0600; stb_i = 1'b1; cyc_i = 1'b1;
    for (int i = 0; i < 200 && xfer_beats < 2; i++) begin @(negedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    chk("midrst_stb_o", {31'h0, stb_o}, 32'h0);
    chk("midrst_cyc_o", {31'h0, cyc_o}, 32'h0);
    chk("midrst_ack_o", {31'h0, ack_o}, 32'h0);
    stb_i = 1'b0; cyc_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    fetch(16'h0500, 1, 0, d, e, beats, lat);
    check_fetch("after_rst_0500", 16'h0500, 1, 32'h0000_0500, 0, 4, 0);
    fetch(16'h0600, 1, 0, d, e, beats, lat);
    check_fetch("after_rst_0600", 16'h0600, 1, 32'h0000_0600, 0, 4, 0);

    // Random traffic against the model, with Wishbone wait states.
    pulse_flush();
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    max_wait = 2;
    for (int i = 0; i < 200; i++) begin
      bit en, fl;
      int eb;
      a  = 16'(($urandom_range(0, 3) << 6) | ($urandom_range(0, 15) << 4) |
               ($urandom_range(0, 3) << 2) | $urandom_range(0, 3));
      en = ($urandom_range(0, 7) != 0);
      fl = ($urandom_range(0, 9) == 0);
      eb = ($urandom_range(0, 7) == 0) ? $urandom_range(1, 4) : 0;
      if (fl) begin
        pulse_flush();
        for (int j = 0; j < 16; j++) m_valid[j] = 1'b0;
      end
      model_fetch(a, en, eb, md, me, mbeats, mlat);
      fetch(a, en, eb, d, e, beats, lat);
      check_fetch($sformatf("rnd%0d", i), a, en, md, me, mbeats, mlat);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, %0d failures so far", n_fail);
    $fatal(1, "timeout");
  end
endmodule
